bwt_sched: RTL and testbench
============================

BWT_SCHED -- requirements
Module: bwt_sched

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst.
REQ-002 Parameter: LOAD_CYCLES, 2, number of cycles core_rst is held high to load a job (minimum 1).
REQ-003 Parameter: TIMEOUT_CYCLES, 64, number of RUN cycles without core_done before a job aborts (minimum 1).
REQ-004 The ports SHALL be exactly these (name, direction, width, meaning):
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  req0_valid  in  1  requester 0 has a job
  req0_data  in  32  requester 0 input word
  req0_ready  out  1  requester 0 job accepted this cycle
  req1_valid  in  1  requester 1 has a job
  req1_data  in  32  requester 1 input word
  req1_ready  out  1  requester 1 job accepted this cycle
  resp_valid  out  1  result available
  resp_ready  in  1  consumer accepts result
  resp_id  out  1  requester index owning the result
  resp_data  out  32  transformed word
  resp_err  out  1  job aborted by timeout
  core_rst  out  1  drives BWT_transform rst
  core_data_in  out  32  drives BWT_transform data_in
  core_done  in  1  BWT_transform done
  core_data_out  in  32  BWT_transform data_out
  busy  out  1  high in every state except IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, LOAD, RUN and RESP.
REQ-006 In IDLE, the grant SHALL go to the only valid requester; if both are valid, it SHALL go to the requester not granted last (round-robin).
REQ-007 reqN_ready SHALL be high combinationally only in IDLE, only for the granted requester; a transfer occurs when valid and ready are both high.
REQ-008 On a transfer, the block SHALL latch the job word and the requester id, clear the cycle counter, and enter LOAD on the next edge.
REQ-009 LOAD SHALL hold core_rst=1 for exactly LOAD_CYCLES cycles, then enter RUN.
REQ-010 core_data_in SHALL equal the latched job word throughout LOAD and RUN, and SHALL hold its last value otherwise.
REQ-011 RUN SHALL hold core_rst=0; core_done SHALL be sampled only in RUN and ignored in every other state.
REQ-012 When core_done=1 in RUN, the block SHALL capture core_data_out into resp_data, clear resp_err, and enter RESP.
REQ-013 RESP SHALL hold resp_valid=1 with resp_data, resp_id and resp_err stable until resp_ready=1; it SHALL return to IDLE on that edge.
REQ-014 No new job SHALL be accepted in the same cycle that a response is accepted; the earliest accept is the following cycle.
REQ-015 In all states except LOAD, core_rst SHALL be 1 in IDLE and RESP (core parked) and 0 in RUN.
REQ-016 Minimum latency from accept to resp_valid SHALL be LOAD_CYCLES + 1 + (RUN cycles until core_done).
REQ-017 The round-robin pointer SHALL update only on a transfer.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL enter IDLE and drive: req0_ready/req1_ready per IDLE rules, resp_valid=0, resp_id=0, resp_data=0, resp_err=0, core_rst=1, core_data_in=0, busy=0.
REQ-019 The reset SHALL set the last-grant pointer to 1, so requester 0 wins the first contention.
REQ-020 A reset in mid-job (LOAD, RUN or RESP) SHALL discard the job with no response.

Configuration
REQ-021 Macro BWT_SCHED_TIMEOUT_EN: when defined, a RUN-cycle counter SHALL abort the job once it reaches TIMEOUT_CYCLES with no core_done, entering RESP with resp_err=1 and resp_data=0.
REQ-022 If core_done and the timeout occur in the same cycle, core_done SHALL take priority.
REQ-023 Without BWT_SCHED_TIMEOUT_EN, RUN SHALL wait indefinitely, the counter SHALL be omitted, and resp_err SHALL be tied to 0.

Verification
REQ-024 Test 1: after reset, req0_valid=1 with req0_data=0x0AB2C1AF -> req0_ready=1 in that cycle; core_rst=1 for 2 cycles with core_data_in=0x0AB2C1AF; core_done with core_data_out=0x1234ABCD -> resp_valid=1, resp_id=0, resp_data=0x1234ABCD.
REQ-025 Test 2: both requesters valid continuously, three jobs -> grants in order 0,1,0; resp_id matches each grant.
REQ-026 Test 3: resp_ready held at 0 for 5 cycles -> resp_valid and resp_data stay stable; req1_ready=0 throughout.
REQ-027 Test 4 (macro defined): core_done never asserted -> after exactly 64 RUN cycles, resp_valid=1, resp_err=1, resp_data=0.
REQ-028 Test 5: rst pulsed during RUN -> next cycle state is IDLE, busy=0, core_rst=1, no response issued, and requester 0 wins the next contention.
REQ-029 Test 6: core_done pulsed during LOAD and during IDLE -> ignored; result is captured only on core_done in RUN.

Source files
------------

// File: rtl/bwt_sched.sv
// Two-requester job scheduler in front of a BWT_transform core: round-robin accept, load, run, respond.
// Optional RUN timeout abort is compiled in with BWT_SCHED_TIMEOUT_EN.
//   state | meaning
//   IDLE  | core parked, waiting for a job
//   LOAD  | core held in reset with the job word applied
//   RUN   | core running, waiting for core_done
//   RESP  | result presented until consumer accepts
module bwt_sched #(
    parameter int LOAD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        core_rst,
    output logic [31:0] core_data_in,
    input  logic        core_done,
    input  logic [31:0] core_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    localparam int MAX_CYC = (LOAD_CYCLES > TIMEOUT_CYCLES) ? LOAD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    logic        last_grant;
    logic        take;
    logic        load_done;
    logic        timeout;
    logic [31:0] job_word;
    logic [31:0] data_q;
    logic        id_q;

    assign load_done = (cnt == LOAD_LAST);

`ifdef BWT_SCHED_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic err_q;
    assign timeout  = (cnt == TO_LAST);
    assign resp_err = err_q;
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    // On contention the requester not granted last wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_grant;
                req1_ready = !last_grant;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign take = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = LOAD;
            LOAD:    if (load_done) state_nxt = RUN;
            RUN:     if (core_done || timeout) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            job_word   <= '0;
            id_q       <= 1'b0;
            data_q     <= '0;
`ifdef BWT_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (take) begin
                    job_word   <= req1_ready ? req1_data : req0_data;
                    id_q       <= req1_ready;
                    last_grant <= req1_ready;
                    cnt        <= '0;
                end
                LOAD: cnt <= load_done ? '0 : cnt + CW'(1);
                RUN: begin
                    // core_done wins over a coincident timeout
                    if (core_done) begin
                        data_q <= core_data_out;
`ifdef BWT_SCHED_TIMEOUT_EN
                        err_q  <= 1'b0;
`endif
                    end else if (timeout) begin
                        data_q <= '0;
`ifdef BWT_SCHED_TIMEOUT_EN
                        err_q  <= 1'b1;
`endif
                    end
`ifdef BWT_SCHED_TIMEOUT_EN
                    cnt <= cnt + CW'(1);
`endif
                end
                default: ;
            endcase
        end
    end

    assign resp_valid   = (state == RESP);
    assign resp_id      = id_q;
    assign resp_data    = data_q;
    assign core_rst     = (state != RUN);
    assign core_data_in = job_word;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_bwt_sched.sv
// Self-checking bench for bwt_sched: table-driven job vectors plus directed corner sequences.
module tb_bwt_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic        resp_valid, resp_id, resp_err, core_rst, busy;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data, core_data_in;
    logic        core_done = 1'b0;
    logic [31:0] core_data_out = '0;

    int total = 0;
    int bad   = 0;

    bwt_sched #(.LOAD_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .core_rst(core_rst), .core_data_in(core_data_in),
        .core_done(core_done), .core_data_out(core_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_rst;
        logic        v0, v1;
        logic [31:0] d0, d1, out;
        logic        gnt;
        int          run_wait;
        int          stall;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_job(input vec_t v);
        logic [31:0] word;
        word = v.gnt ? v.d1 : v.d0;
        req0_valid = v.v0; req1_valid = v.v1;
        req0_data  = v.d0; req1_data  = v.d1;
        #1;
        chk("idle_rdy0", req0_ready, !v.gnt);
        chk("idle_rdy1", req1_ready, v.gnt);
        chk("idle_busy", busy, 0);
        chk("idle_core_rst", core_rst, 1);
        step();
        for (int i = 0; i < 2; i++) begin
            chk("load_core_rst", core_rst, 1);
            chk("load_data", core_data_in, word);
            chk("load_rdy", req0_ready | req1_ready, 0);
            chk("load_busy", busy, 1);
            step();
        end
        chk("run_core_rst", core_rst, 0);
        chk("run_data", core_data_in, word);
        repeat (v.run_wait) begin
            step();
            chk("run_wait_valid", resp_valid, 0);
        end
        core_done = 1'b1; core_data_out = v.out;
        step();
        core_done = 1'b0; core_data_out = 32'hFFFF_FFFF;
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, v.gnt);
        chk("resp_data", resp_data, v.out);
        chk("resp_err", resp_err, 0);
        chk("resp_core_rst", core_rst, 1);
        for (int i = 0; i < v.stall; i++) begin
            step();
            chk("stall_valid", resp_valid, 1);
            chk("stall_data", resp_data, v.out);
            chk("stall_id", resp_id, v.gnt);
            chk("stall_rdy1", req1_ready, 0);
            chk("stall_rdy0", req0_ready, 0);
        end
        resp_ready = 1'b1;
        #1;
        chk("resp_accept_rdy", req0_ready | req1_ready, 0);
        step();
        resp_ready = 1'b0;
        chk("after_resp_valid", resp_valid, 0);
        chk("after_resp_busy", busy, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0AB2_C1AF, 32'h0, 32'h1234_ABCD, 1'b0, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1111_0001, 32'h2222_0001, 32'hA000_0001, 1'b0, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h1111_0002, 32'h2222_0002, 32'hA000_0002, 1'b1, 3, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h1111_0003, 32'h2222_0003, 32'hA000_0003, 1'b0, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h1111_0004, 32'h2222_0004, 32'hA000_0004, 1'b1, 0, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h1111_0005, 32'h2222_0005, 32'hA000_0005, 1'b0, 2, 0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h1111_0006, 32'h2222_0006, 32'hA000_0006, 1'b1, 0, 5};

        do_reset();
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_data_in", core_data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", req0_ready | req1_ready, 0);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].do_rst) do_reset();
            do_job(vecs[k]);
        end

        // Reset in mid-RUN on a requester-0 job: discarded, pointer restored.
        req0_valid = 1'b1; req1_valid = 1'b0; req0_data = 32'h5555_AAAA;
        step();
        req0_valid = 1'b0;
        step(); step();
        chk("t5_in_run", core_rst, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_core_rst", core_rst, 1);
        chk("t5_resp_valid", resp_valid, 0);
        chk("t5_core_data_in", core_data_in, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("t5_rr_rdy0", req0_ready, 1);
        chk("t5_rr_rdy1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) begin
            step();
            chk("t5_no_resp", resp_valid, 0);
        end

        // core_done outside RUN is ignored.
        core_done = 1'b1; core_data_out = 32'hDEAD_BEEF;
        step();
        core_done = 1'b0;
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_valid", resp_valid, 0);
        req1_valid = 1'b1; req1_data = 32'h0C0F_FEE0;
        step();
        req1_valid = 1'b0;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("t6_load_still", core_rst, 1);
        chk("t6_load_valid", resp_valid, 0);
        step();
        chk("t6_run", core_rst, 0);
        step();
        chk("t6_run_valid", resp_valid, 0);
        core_done = 1'b1; core_data_out = 32'h600D_F00D;
        step();
        core_done = 1'b0;
        chk("t6_resp_valid", resp_valid, 1);
        chk("t6_resp_data", resp_data, 32'h600D_F00D);
        chk("t6_resp_id", resp_id, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // RUN with no core_done.
        req0_valid = 1'b1; req0_data = 32'h7777_0000;
        step();
        req0_valid = 1'b0;
        step(); step();
        chk("to_run_entry", core_rst, 0);
`ifdef BWT_SCHED_TIMEOUT_EN
        repeat (63) step();
        chk("to_before", resp_valid, 0);
        step();
        chk("to_valid", resp_valid, 1);
        chk("to_err", resp_err, 1);
        chk("to_data", resp_data, 0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        step(); step();
        repeat (63) step();
        core_done = 1'b1; core_data_out = 32'h0000_BEEF;
        step();
        core_done = 1'b0;
        chk("to_tie_valid", resp_valid, 1);
        chk("to_tie_err", resp_err, 0);
        chk("to_tie_data", resp_data, 32'h0000_BEEF);
`else
        repeat (100) step();
        chk("nto_busy", busy, 1);
        chk("nto_valid", resp_valid, 0);
        chk("nto_core_rst", core_rst, 0);
        core_done = 1'b1; core_data_out = 32'h0000_BEEF;
        step();
        core_done = 1'b0;
        chk("nto_valid_late", resp_valid, 1);
        chk("nto_err", resp_err, 0);
        chk("nto_data", resp_data, 32'h0000_BEEF);
`endif
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("end_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
